// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two ALU requesters and the sharing controller.
// master = requester side, slave = alu_share_ctrl side.
interface alu_share_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [7:0]          req_opcode;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [DATA_W-1:0]   resp_result;
  logic                resp_zero;
  logic                resp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one single-cycle ALU between two requesters.
// One transaction in flight: IDLE (grant) -> EXEC (ALU cycle) -> RESP (hold until consumed).
module alu_share_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_ctrl_if.slave   bus,
  output logic [3:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_operandA,
  output logic [DATA_W-1:0] alu_operandB,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;

  logic grant_en;
  logic grant_idx;

  // On contention the round-robin pointer decides; otherwise the lone requester wins.
  always_comb begin
    grant_idx     = (bus.req_valid == 2'b11) ? rr_ptr_q : bus.req_valid[1];
    grant_en      = (state_q == IDLE) && (|bus.req_valid) && !reset;
    bus.req_ready = grant_en ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          owner_d = grant_idx;
          op_d    = grant_idx ? bus.req_opcode[7:4] : bus.req_opcode[3:0];
          a_d     = grant_idx ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
          b_d     = grant_idx ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_zero;
        err_d    = op_q[3];
        state_d  = RESP;
      end
      RESP: begin
        if (bus.resp_ready[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    alu_opcode      = op_q;
    alu_operandA    = a_q;
    alu_operandB    = b_q;
    bus.resp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    bus.resp_result = result_q;
    bus.resp_zero   = zero_q;
    bus.resp_err    = err_q;
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table of single transactions plus
// hand-written contention, backpressure, reset-abort and non-owner sequences.
module tb_alu_share_ctrl;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [31:0] alu_result;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl_if #(.DATA_W(32)) bus ();

  alu_share_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_opcode   (alu_opcode),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU: unsigned SLT, shift by B[4:0], undefined opcodes give 0.
  always_comb begin
    case (alu_opcode)
      OP_ADD:  alu_result = alu_operandA + alu_operandB;
      OP_SUB:  alu_result = alu_operandA - alu_operandB;
      OP_AND:  alu_result = alu_operandA & alu_operandB;
      OP_OR:   alu_result = alu_operandA | alu_operandB;
      OP_XOR:  alu_result = alu_operandA ^ alu_operandB;
      OP_SLL:  alu_result = alu_operandA << alu_operandB[4:0];
      OP_SRL:  alu_result = alu_operandA >> alu_operandB[4:0];
      OP_SLT:  alu_result = {31'b0, alu_operandA < alu_operandB};
      default: alu_result = 32'h0;
    endcase
    alu_zero = (alu_result == 32'h0);
  end

  typedef struct {
    bit          idx;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (idx) begin
      bus.req_valid  = 2'b10;
      bus.req_opcode = {op, 4'h0};
      bus.req_a      = {a, 32'h0};
      bus.req_b      = {b, 32'h0};
    end else begin
      bus.req_valid  = 2'b01;
      bus.req_opcode = {4'h0, op};
      bus.req_a      = {32'h0, a};
      bus.req_b      = {32'h0, b};
    end
  endtask

  // Full transaction: accept, EXEC, RESP consumed in its first cycle.
  task automatic run_op(input string tag, input bit idx, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic zero, input logic err);
    logic [1:0] onehot;
    onehot = idx ? 2'b10 : 2'b01;
    apply_stimulus(idx, op, a, b);
    #1;
    check_output({tag, "_req_ready"}, 32'(bus.req_ready), 32'(onehot));
    tick();
    bus.req_valid  = 2'b00;
    bus.req_opcode = 8'hFF;
    bus.req_a      = '1;
    bus.req_b      = '1;
    #1;
    check_output({tag, "_exec_ready"}, 32'(bus.req_ready), 32'h0);
    check_output({tag, "_exec_valid"}, 32'(bus.resp_valid), 32'h0);
    check_output({tag, "_alu_op"}, 32'(alu_opcode), 32'(op));
    check_output({tag, "_alu_a"}, alu_operandA, a);
    check_output({tag, "_alu_b"}, alu_operandB, b);
    tick();
    check_output({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'(onehot));
    check_output({tag, "_result"}, bus.resp_result, res);
    check_output({tag, "_zero"}, 32'(bus.resp_zero), 32'(zero));
    check_output({tag, "_err"}, 32'(bus.resp_err), 32'(err));
    bus.resp_ready = onehot;
    tick();
    bus.resp_ready = 2'b00;
    #1;
    check_output({tag, "_done_valid"}, 32'(bus.resp_valid), 32'h0);
  endtask

  initial begin
    vecs[0] = '{1'b0, OP_ADD, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'b1010, 32'd9,       32'd9,        32'd0,        1'b1, 1'b1};
    vecs[2] = '{1'b1, OP_SLL, 32'd1,        32'd33,       32'd2,        1'b0, 1'b0};
    vecs[3] = '{1'b0, OP_SLT, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
    vecs[4] = '{1'b1, OP_SLT, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0};
    vecs[5] = '{1'b0, OP_SRL, 32'h80000000, 32'd31,       32'd1,        1'b0, 1'b0};
    vecs[6] = '{1'b1, OP_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, OP_SUB, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 4'hF,   32'd1,        32'd1,        32'd0,        1'b1, 1'b1};

    reset          = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_opcode = 8'h00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 2'b00;
    tick();
    tick();
    check_output("rst_req_ready", 32'(bus.req_ready), 32'h0);
    reset         = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    check_output("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_output("rst_alu_op", 32'(alu_opcode), 32'h0);
    check_output("rst_alu_a", alu_operandA, 32'h0);
    check_output("rst_alu_b", alu_operandB, 32'h0);
    check_output("rst_result", bus.resp_result, 32'h0);
    check_output("rst_zero", 32'(bus.resp_zero), 32'h0);
    check_output("rst_err", 32'(bus.resp_err), 32'h0);

    // Contention straight after reset: req0 first, then req1 while both still request.
    bus.req_valid  = 2'b11;
    bus.req_opcode = {OP_OR, OP_SUB};
    bus.req_a      = {32'h000000F0, 32'd3};
    bus.req_b      = {32'h0000000F, 32'd3};
    #1;
    check_output("rr_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    check_output("rr_exec_ready", 32'(bus.req_ready), 32'h0);
    check_output("rr_exec_a", alu_operandA, 32'd3);
    tick();
    check_output("rr_resp0_valid", 32'(bus.resp_valid), 32'h1);
    check_output("rr_resp0_result", bus.resp_result, 32'h0);
    check_output("rr_resp0_zero", 32'(bus.resp_zero), 32'h1);
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    #1;
    check_output("rr_second_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check_output("rr_resp1_valid", 32'(bus.resp_valid), 32'h2);
    check_output("rr_resp1_result", bus.resp_result, 32'hFF);
    check_output("rr_resp1_zero", 32'(bus.resp_zero), 32'h0);
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = 2'b00;
    bus.req_valid  = 2'b11;
    #1;
    check_output("rr_third_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();
    check_output("withdraw_valid", 32'(bus.resp_valid), 32'h0);
    check_output("withdraw_op", 32'(alu_opcode), 32'(OP_OR));

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].zero, vecs[i].err);
    end

    // Backpressure: a new request waits while the response is held for 4 cycles.
    apply_stimulus(1'b0, OP_ADD, 32'd10, 32'd20);
    tick();
    apply_stimulus(1'b0, OP_ADD, 32'd1, 32'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("bp%0d_valid", k), 32'(bus.resp_valid), 32'h1);
      check_output($sformatf("bp%0d_result", k), bus.resp_result, 32'd30);
      check_output($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.resp_ready = 2'b01;
    #1;
    check_output("bp_hs_ready", 32'(bus.req_ready), 32'h0);
    tick();
    bus.resp_ready = 2'b00;
    #1;
    check_output("bp_resume_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    check_output("bp_next_result", bus.resp_result, 32'd2);
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;

    // Non-owner resp_ready must not complete the transaction.
    apply_stimulus(1'b0, OP_SUB, 32'd0, 32'd1);
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.resp_ready = 2'b10;
    tick();
    check_output("nonowner_valid", 32'(bus.resp_valid), 32'h1);
    check_output("nonowner_result", bus.resp_result, 32'hFFFFFFFF);
    bus.resp_ready = 2'b11;
    tick();
    bus.resp_ready = 2'b00;
    check_output("owner_done_valid", 32'(bus.resp_valid), 32'h0);

    // Reset during EXEC aborts the op and clears rr_ptr (it is 1 after serving req0).
    apply_stimulus(1'b0, OP_AND, 32'hFF, 32'h0F);
    tick();
    bus.req_valid = 2'b11;
    reset         = 1'b1;
    #1;
    check_output("abort_rst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    reset         = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    check_output("abort_valid0", 32'(bus.resp_valid), 32'h0);
    check_output("abort_alu_op", 32'(alu_opcode), 32'h0);
    tick();
    check_output("abort_valid1", 32'(bus.resp_valid), 32'h0);
    bus.req_valid = 2'b11;
    #1;
    check_output("abort_rr_reset", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    tick();
    check_output("abort_valid2", 32'(bus.resp_valid), 32'h0);
    run_op("post_abort_xor", 1'b1, OP_XOR, 32'hA5, 32'hFF, 32'h5A, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
